// File: rtl/io_bitbang_pkg.sv
// Shared constants, FSM state encoding and byte-count helper for the io_bitbang
// command controller.
package io_bitbang_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_DIR_OUT   = 3'd1;
  localparam logic [2:0] OP_DIR_IN    = 3'd2;
  localparam logic [2:0] OP_DRIVE_HI  = 3'd3;
  localparam logic [2:0] OP_DRIVE_LO  = 3'd4;
  localparam logic [2:0] OP_READ      = 3'd5;
  localparam logic [2:0] OP_READ_ALL  = 3'd6;
  localparam logic [2:0] OP_RESET_ALL = 3'd7;

  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam logic [7:0] ACK_BYTE = 8'hA5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RSP     = 2'd1;
  localparam state_t ST_RSP_ALL = 2'd2;

  // Number of response bytes needed to carry n pin bits.
  function automatic int nb_bytes(input int n);
    return (n + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs; both stages reset to 0.
module io_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] q_r;

  // Metastability filter: two back-to-back capture stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q_r    <= '0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/io_bitbang_ctrl.sv
// Byte-command controller for io_bitbang: pin direction/drive registers plus
// synchronised pad readback. Define IO_BITBANG_CTRL_ACK_EN to acknowledge writes with 0xA5.
module io_bitbang_ctrl
  import io_bitbang_pkg::*;
#(
  parameter int IO_NUM_OF = 10
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_cmd_valid,
  input  logic [7:0]           in_cmd_data,
  output logic                 out_cmd_ready,
  output logic                 out_rsp_valid,
  output logic [7:0]           out_rsp_data,
  input  logic                 in_rsp_ready,
  input  logic [IO_NUM_OF-1:0] in_io_pins,
  output logic [IO_NUM_OF-1:0] out_io_direction,
  output logic [IO_NUM_OF-1:0] out_io_outval
);

  if (IO_NUM_OF < 1 || IO_NUM_OF > 32) begin : g_bad_io_num
    $error("io_bitbang_ctrl: IO_NUM_OF must be within 1..32");
  end

  localparam logic [5:0] NUM_L  = 6'(IO_NUM_OF);
  localparam logic [1:0] LAST_L = 2'(nb_bytes(IO_NUM_OF) - 1);
`ifdef IO_BITBANG_CTRL_ACK_EN
  localparam logic ACK_EN_L = 1'b1;
`else
  localparam logic ACK_EN_L = 1'b0;
`endif

  logic [IO_NUM_OF-1:0] sync_s;
  logic [31:0]          sync_pad_s;
  logic [IO_NUM_OF-1:0] mask_s;
  logic [2:0]           op_s;
  logic [4:0]           pin_s;
  logic                 needs_idx_s;
  logic                 idx_ok_s;

  state_t               state_r, state_n_s;
  logic [IO_NUM_OF-1:0] dir_r, dir_n_s;
  logic [IO_NUM_OF-1:0] outval_r, outval_n_s;
  logic [7:0]           rsp_data_r, rsp_data_n_s;
  logic [1:0]           cnt_r, cnt_n_s;
  logic [31:0]          snap_r, snap_n_s;
  logic                 cmd_ready_r;
  logic                 rsp_valid_r;

  io_sync2 #(.W(IO_NUM_OF)) u_sync (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .d     (in_io_pins),
    .q     (sync_s)
  );

  assign sync_pad_s  = 32'(sync_s);
  assign op_s        = in_cmd_data[7:5];
  assign pin_s       = in_cmd_data[4:0];
  assign needs_idx_s = (op_s >= OP_DIR_OUT) && (op_s <= OP_READ);
  assign idx_ok_s    = ({1'b0, pin_s} < NUM_L);

  // One-hot select of the addressed pin.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < IO_NUM_OF; i++) begin
      mask_s[i] = (pin_s == 5'(i));
    end
  end

  // Command decode and response sequencing.
  always_comb begin
    state_n_s    = state_r;
    dir_n_s      = dir_r;
    outval_n_s   = outval_r;
    rsp_data_n_s = rsp_data_r;
    cnt_n_s      = cnt_r;
    snap_n_s     = snap_r;
    case (state_r)
      ST_IDLE: begin
        if (in_cmd_valid) begin
          if (needs_idx_s && !idx_ok_s) begin
            state_n_s    = ST_RSP;
            rsp_data_n_s = ERR_BYTE;
          end else begin
            case (op_s)
              OP_DIR_OUT:   dir_n_s    = dir_r | mask_s;
              OP_DIR_IN:    dir_n_s    = dir_r & ~mask_s;
              OP_DRIVE_HI:  outval_n_s = outval_r | mask_s;
              OP_DRIVE_LO:  outval_n_s = outval_r & ~mask_s;
              OP_RESET_ALL: begin
                dir_n_s    = '0;
                outval_n_s = '0;
              end
              default: begin
              end
            endcase
            case (op_s)
              OP_READ: begin
                snap_n_s     = sync_pad_s;
                rsp_data_n_s = {7'd0, sync_pad_s[pin_s]};
                state_n_s    = ST_RSP;
              end
              OP_READ_ALL: begin
                snap_n_s     = sync_pad_s;
                rsp_data_n_s = sync_pad_s[7:0];
                cnt_n_s      = 2'd0;
                state_n_s    = ST_RSP_ALL;
              end
              default: begin
                if (ACK_EN_L) begin
                  rsp_data_n_s = ACK_BYTE;
                  state_n_s    = ST_RSP;
                end else begin
                end
              end
            endcase
          end
        end else begin
        end
      end
      ST_RSP: begin
        if (in_rsp_ready) begin
          state_n_s = ST_IDLE;
        end else begin
        end
      end
      ST_RSP_ALL: begin
        if (in_rsp_ready) begin
          if (cnt_r == LAST_L) begin
            state_n_s = ST_IDLE;
          end else begin
            cnt_n_s      = cnt_r + 2'd1;
            rsp_data_n_s = snap_r[{cnt_r + 2'd1, 3'b000} +: 8];
          end
        end else begin
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State and output registers; ready/valid are registered decodes of the next state.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r     <= ST_IDLE;
      dir_r       <= '0;
      outval_r    <= '0;
      rsp_data_r  <= 8'd0;
      cnt_r       <= 2'd0;
      snap_r      <= 32'd0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      dir_r       <= dir_n_s;
      outval_r    <= outval_n_s;
      rsp_data_r  <= rsp_data_n_s;
      cnt_r       <= cnt_n_s;
      snap_r      <= snap_n_s;
      cmd_ready_r <= (state_n_s == ST_IDLE);
      rsp_valid_r <= (state_n_s != ST_IDLE);
    end
  end

  assign out_cmd_ready    = cmd_ready_r;
  assign out_rsp_valid    = rsp_valid_r;
  assign out_rsp_data     = rsp_data_r;
  assign out_io_direction = dir_r;
  assign out_io_outval    = outval_r;

endmodule

// File: doc/io_bitbang_ctrl.md
# io_bitbang_ctrl

- Byte-command controller directly upstream of `io_bitbang`.
- Accepts single-byte pin commands on a valid/ready stream and holds the per-pin direction and drive-value registers that feed `in_io_direction`/`in_io_outval`.
- Synchronises sampled pad values and returns them as response bytes on a second valid/ready stream.
- Typical host link: a UART or SPI byte receiver.

## Interface
Parameters:
- `IO_NUM_OF`, default 10: number of controlled pins. Legal range 1..32; elaboration fails outside it.

Ports:
- `in_clk`, input, 1: the single clock.
- `in_rst_n`, input, 1: reset, asynchronous and active-low.
- `in_cmd_valid`, input, 1: command byte valid.
- `in_cmd_data`, input, 8: command byte.
- `out_cmd_ready`, output, 1: controller can accept a command.
- `out_rsp_valid`, output, 1: response byte valid.
- `out_rsp_data`, output, 8: response byte.
- `in_rsp_ready`, input, 1: consumer accepts the response byte.
- `in_io_pins`, input, IO_NUM_OF: raw pad values, asynchronous.
- `out_io_direction`, output, IO_NUM_OF: 1 = drive; connects to `io_bitbang.in_io_direction`.
- `out_io_outval`, output, IO_NUM_OF: drive values; connects to `io_bitbang.in_io_outval`.

## Operation
Command byte format:
- [7:5] opcode.
- [4:0] pin index `p`.

Opcodes:
- 0 NOP: no effect, no response.
- 1 DIR_OUT: `direction[p]` <= 1.
- 2 DIR_IN: `direction[p]` <= 0.
- 3 DRIVE_HI: `outval[p]` <= 1.
- 4 DRIVE_LO: `outval[p]` <= 0.
- 5 READ: response 0x00 or 0x01 = `sync[p]`.
- 6 READ_ALL: NB = (IO_NUM_OF+7)/8 response bytes.
  - LSB byte first; byte k = `sync[8k+7:8k]`.
  - Bits at or above IO_NUM_OF read as 0.
  - Index field is ignored.
- 7 RESET_ALL: `direction` and `outval` cleared to 0. Index is ignored.

Index check:
- Applies to opcodes 1–5 only.
- If `p` >= IO_NUM_OF, the command has no register effect and the response is the single byte ERR = 0xEE.

Synchroniser:
- `in_io_pins` passes through 2 flops before use (`sync`).
- READ on a pin that is being driven returns the synchronised pad value, not the `outval` register.

FSM states: IDLE, RSP, RSP_ALL.
- IDLE: `out_cmd_ready`=1.
  - On accept of a command with no response: stay in IDLE.
  - On accept of READ or ERR: go to RSP.
  - On accept of READ_ALL: go to RSP_ALL with byte counter = 0.
- RSP: `out_rsp_valid`=1. On `in_rsp_ready`, go to IDLE.
- RSP_ALL: `out_rsp_valid`=1. On `in_rsp_ready`:
  - If counter = NB-1, go to IDLE.
  - Otherwise increment the counter.
- `out_cmd_ready`=0 in every non-IDLE state; no command queueing.

Snapshots:
- READ and READ_ALL latch the full `sync` vector into a snapshot register on the accept edge.
- All bytes of one READ_ALL are taken from that single snapshot.

Reset values:
- `out_io_direction`=0, `out_io_outval`=0 (all pins high-Z).
- `out_cmd_ready`=1, `out_rsp_valid`=0, `out_rsp_data`=0.
- Synchroniser flops = 0; state = IDLE.
- Reset asserted mid-response aborts the response: `out_rsp_valid` drops immediately and the pending bytes are discarded.

## Timing
- Command accepted on a rising edge with `in_cmd_valid` & `out_cmd_ready`.
- Register updates are visible on `out_io_*` one cycle after the accept edge (registered outputs, 1-cycle latency).
- `out_rsp_valid` rises the cycle after accept.
- `out_rsp_data` is registered and stable while valid is high and ready is low.
- Back-to-back write commands sustain one per cycle.
- READ turnaround: the next command can be accepted the cycle after the response handshake.
- Pad-to-readable latency: 2 cycles of synchronisation, then capture on the accept edge.
- Valid/ready rules: valid never drops without a handshake; data does not change while valid=1 and ready=0.

## Configuration
Macro `IO_BITBANG_CTRL_ACK_EN`:
- Defined: every accepted opcode 0–4 and 7 with a valid index returns the single response byte ACK = 0xA5 and goes to RSP. Index is ignored for opcodes 0 and 7.
- Not defined: those opcodes produce no response, as described in Operation.
- ERR behaviour is identical in both builds.

## Structure
- Package `io_bitbang_pkg` holds:
  - Opcode constants.
  - ERR (0xEE) and ACK (0xA5) byte constants.
  - The NB byte-count function.
  - The FSM state typedef.
- Sub-module `io_sync2`: parameterised-width 2-flop synchroniser with async active-low reset to 0.

## Test plan
- Reset, then DIR_OUT p=3 (0x23), then DRIVE_HI p=3 (0x63) → `out_io_direction`=0x008 and `out_io_outval`=0x008, each one cycle after its accept.
- `in_io_pins`=0x2A5 held, then READ p=2 (0xA2) → one response byte 0x01; READ p=1 → 0x00.
- Same pins, READ_ALL (0xC0) with `in_rsp_ready` toggling every other cycle → bytes 0xA5 then 0x02; `out_cmd_ready`=0 throughout.
- DRIVE_LO p=12 (0x8C) with IO_NUM_OF=10 → response 0xEE; `out_io_outval` unchanged.
- Set several pins, then RESET_ALL (0xE0) → both vectors 0; with `IO_BITBANG_CTRL_ACK_EN` defined, response 0xA5.
- `in_rst_n` asserted during the second READ_ALL byte → `out_rsp_valid`=0 immediately, outputs return to reset values, next command accepted normally.
